// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS-subset main control FSM:
// state encodings, opcode values, datapath mux selects and ULA operation codes.
package mc_pkg;

  typedef enum logic [4:0] {
    FETCH    = 5'd0,
    DECODE   = 5'd1,
    RTYPE_EX = 5'd2,
    RTYPE_WB = 5'd3,
    ADDI_EX  = 5'd4,
    ADDI_WB  = 5'd5,
    MEMADR   = 5'd6,
    MEMRD    = 5'd7,
    MEMWB    = 5'd8,
    MEMWR    = 5'd9,
    BEQ      = 5'd10,
    JUMP     = 5'd11,
    EXC      = 5'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [2:0] ULA_ADD   = 3'b001;
  localparam logic [2:0] ULA_SUB   = 3'b010;
  localparam logic [2:0] ULA_FUNCT = 3'b111;

  localparam logic [2:0] SRCA_PC  = 3'd0;
  localparam logic [2:0] SRCA_A   = 3'd1;
  localparam logic [2:0] SRCB_B   = 3'd0;
  localparam logic [2:0] SRCB_4   = 3'd1;
  localparam logic [2:0] SRCB_IMM = 3'd2;
  localparam logic [2:0] SRCB_BR  = 3'd3;

  localparam logic [2:0] ADDR_PC  = 3'd0;
  localparam logic [2:0] ADDR_ALU = 3'd1;

  localparam logic [2:0] WREG_RT  = 3'd0;
  localparam logic [2:0] WREG_RD  = 3'd1;
  localparam logic [2:0] WDAT_ALU = 3'd0;
  localparam logic [2:0] WDAT_MDR = 3'd1;

  localparam logic [2:0] PC_ALU   = 3'd0;
  localparam logic [2:0] PC_BR    = 3'd1;
  localparam logic [2:0] PC_JUMP  = 3'd2;
  localparam logic [2:0] PC_EXC   = 3'd3;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational state -> control-word decoder. Every output is forced to 0
// while enable is low so a reset aborts any in-flight memory access at once.
module mc_ctrl_decode
  import mc_pkg::*;
#(
  parameter int SEL_W = 3
) (
  input  logic [4:0]       stateCode,
  input  logic             enable,
  input  logic             memRdy,
  input  logic             zero,
  output logic             Load_PC,
  output logic             Load_IR,
  output logic             Load_A,
  output logic             Load_B,
  output logic             Load_ULAOut,
  output logic             Load_MDR,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             MemRead,
  output logic [SEL_W-1:0] IorD,
  output logic [SEL_W-1:0] ULAsrcA,
  output logic [SEL_W-1:0] ULAsrcB,
  output logic [SEL_W-1:0] ULA_select,
  output logic [SEL_W-1:0] WriteRegMux,
  output logic [SEL_W-1:0] WriteDataMux,
  output logic [SEL_W-1:0] PCSource,
  output logic             exc
);

  always_comb begin
    Load_PC      = 1'b0;
    Load_IR      = 1'b0;
    Load_A       = 1'b0;
    Load_B       = 1'b0;
    Load_ULAOut  = 1'b0;
    Load_MDR     = 1'b0;
    RegWrite     = 1'b0;
    MemWrite     = 1'b0;
    MemRead      = 1'b0;
    IorD         = '0;
    ULAsrcA      = '0;
    ULAsrcB      = '0;
    ULA_select   = '0;
    WriteRegMux  = '0;
    WriteDataMux = '0;
    PCSource     = '0;
    exc          = 1'b0;
    if (enable) begin
      case (state_t'(stateCode))
        FETCH: begin
          IorD       = SEL_W'(ADDR_PC);
          MemRead    = 1'b1;
          ULAsrcA    = SEL_W'(SRCA_PC);
          ULAsrcB    = SEL_W'(SRCB_4);
          ULA_select = SEL_W'(ULA_ADD);
          PCSource   = SEL_W'(PC_ALU);
          Load_IR    = memRdy;
          Load_PC    = memRdy;
        end
        DECODE: begin
          Load_A      = 1'b1;
          Load_B      = 1'b1;
          ULAsrcA     = SEL_W'(SRCA_PC);
          ULAsrcB     = SEL_W'(SRCB_BR);
          ULA_select  = SEL_W'(ULA_ADD);
          Load_ULAOut = 1'b1;
        end
        RTYPE_EX: begin
          ULAsrcA     = SEL_W'(SRCA_A);
          ULAsrcB     = SEL_W'(SRCB_B);
          ULA_select  = SEL_W'(ULA_FUNCT);
          Load_ULAOut = 1'b1;
        end
        RTYPE_WB: begin
          RegWrite     = 1'b1;
          WriteRegMux  = SEL_W'(WREG_RD);
          WriteDataMux = SEL_W'(WDAT_ALU);
        end
        ADDI_EX, MEMADR: begin
          ULAsrcA     = SEL_W'(SRCA_A);
          ULAsrcB     = SEL_W'(SRCB_IMM);
          ULA_select  = SEL_W'(ULA_ADD);
          Load_ULAOut = 1'b1;
        end
        ADDI_WB: begin
          RegWrite     = 1'b1;
          WriteRegMux  = SEL_W'(WREG_RT);
          WriteDataMux = SEL_W'(WDAT_ALU);
        end
        MEMRD: begin
          IorD     = SEL_W'(ADDR_ALU);
          MemRead  = 1'b1;
          Load_MDR = memRdy;
        end
        MEMWB: begin
          RegWrite     = 1'b1;
          WriteRegMux  = SEL_W'(WREG_RT);
          WriteDataMux = SEL_W'(WDAT_MDR);
        end
        MEMWR: begin
          IorD     = SEL_W'(ADDR_ALU);
          MemWrite = 1'b1;
        end
        BEQ: begin
          ULAsrcA    = SEL_W'(SRCA_A);
          ULAsrcB    = SEL_W'(SRCB_B);
          ULA_select = SEL_W'(ULA_SUB);
          PCSource   = SEL_W'(PC_BR);
          Load_PC    = zero;
        end
        JUMP: begin
          PCSource = SEL_W'(PC_JUMP);
          Load_PC  = 1'b1;
        end
        EXC: begin
          exc      = 1'b1;
          PCSource = SEL_W'(PC_EXC);
          Load_PC  = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS-subset main control FSM: state register and next-state logic;
// the control word itself comes from mc_ctrl_decode.
module mc_control_fsm
  import mc_pkg::*;
#(
  parameter int OP_W     = 6,
  parameter int SEL_W    = 3,
  parameter int STATE_W  = 5,
  parameter int MEM_WAIT = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [OP_W-1:0]    opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               Load_PC,
  output logic               Load_IR,
  output logic               Load_A,
  output logic               Load_B,
  output logic               Load_ULAOut,
  output logic               Load_MDR,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic               MemRead,
  output logic [SEL_W-1:0]   IorD,
  output logic [SEL_W-1:0]   ULAsrcA,
  output logic [SEL_W-1:0]   ULAsrcB,
  output logic [SEL_W-1:0]   ULA_select,
  output logic [SEL_W-1:0]   WriteRegMux,
  output logic [SEL_W-1:0]   WriteDataMux,
  output logic [SEL_W-1:0]   PCSource,
  output logic               exc,
  output logic [STATE_W-1:0] state
);

  state_t state_q, state_d;
  logic   memRdy;
  logic   unusedFunct;

  // funct only steers the ULA through ULA_select=111; the FSM never branches on it.
  assign unusedFunct = ^funct;
  assign memRdy      = (MEM_WAIT != 0) ? mem_ready : 1'b1;
  assign state       = STATE_W'(state_q);

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:    state_d = memRdy ? DECODE : FETCH;
      DECODE: begin
        if      (opcode == OP_W'(OP_RTYPE)) state_d = RTYPE_EX;
        else if (opcode == OP_W'(OP_ADDI))  state_d = ADDI_EX;
        else if (opcode == OP_W'(OP_LW) ||
                 opcode == OP_W'(OP_SW))    state_d = MEMADR;
        else if (opcode == OP_W'(OP_BEQ))   state_d = BEQ;
        else if (opcode == OP_W'(OP_J))     state_d = JUMP;
        else                                state_d = EXC;
      end
      RTYPE_EX: state_d = RTYPE_WB;
      ADDI_EX:  state_d = ADDI_WB;
      // IR only loads in FETCH, so the opcode is still valid for this second decode.
      MEMADR: begin
        if      (opcode == OP_W'(OP_LW)) state_d = MEMRD;
        else if (opcode == OP_W'(OP_SW)) state_d = MEMWR;
        else                             state_d = FETCH;
      end
      MEMRD:    state_d = memRdy ? MEMWB : MEMRD;
      MEMWR:    state_d = memRdy ? FETCH : MEMWR;
      default:  state_d = FETCH;
    endcase
  end

  mc_ctrl_decode #(.SEL_W(SEL_W)) uDecode (
    .stateCode    (state_q),
    .enable       (reset_n),
    .memRdy       (memRdy),
    .zero         (zero),
    .Load_PC      (Load_PC),
    .Load_IR      (Load_IR),
    .Load_A       (Load_A),
    .Load_B       (Load_B),
    .Load_ULAOut  (Load_ULAOut),
    .Load_MDR     (Load_MDR),
    .RegWrite     (RegWrite),
    .MemWrite     (MemWrite),
    .MemRead      (MemRead),
    .IorD         (IorD),
    .ULAsrcA      (ULAsrcA),
    .ULAsrcB      (ULAsrcB),
    .ULA_select   (ULA_select),
    .WriteRegMux  (WriteRegMux),
    .WriteDataMux (WriteDataMux),
    .PCSource     (PCSource),
    .exc          (exc)
  );

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed testbench for mc_control_fsm: walks each instruction class through
// the FSM with hand-computed state and control-word expectations.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       Load_PC, Load_IR, Load_A, Load_B, Load_ULAOut, Load_MDR;
  logic       RegWrite, MemWrite, MemRead, exc;
  logic [2:0] IorD, ULAsrcA, ULAsrcB, ULA_select, WriteRegMux, WriteDataMux, PCSource;
  logic [4:0] state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mc_control_fsm #(.OP_W(6), .SEL_W(3), .STATE_W(5), .MEM_WAIT(1)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .opcode       (opcode),
    .funct        (funct),
    .zero         (zero),
    .mem_ready    (mem_ready),
    .Load_PC      (Load_PC),
    .Load_IR      (Load_IR),
    .Load_A       (Load_A),
    .Load_B       (Load_B),
    .Load_ULAOut  (Load_ULAOut),
    .Load_MDR     (Load_MDR),
    .RegWrite     (RegWrite),
    .MemWrite     (MemWrite),
    .MemRead      (MemRead),
    .IorD         (IorD),
    .ULAsrcA      (ULAsrcA),
    .ULAsrcB      (ULAsrcB),
    .ULA_select   (ULA_select),
    .WriteRegMux  (WriteRegMux),
    .WriteDataMux (WriteDataMux),
    .PCSource     (PCSource),
    .exc          (exc),
    .state        (state)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // One clock: outputs are sampled 1 ns after the rising edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; opcode = 6'd8; funct = 6'd32; zero = 1'b0; mem_ready = 1'b1;

    // Reset: enables stay low even though mem_ready is high.
    applyStimulus();
    checkOutput("rst_Load_PC", Load_PC, 0);
    checkOutput("rst_Load_IR", Load_IR, 0);
    checkOutput("rst_MemRead", MemRead, 0);
    checkOutput("rst_ULAsrcB", ULAsrcB, 0);
    applyStimulus();
    reset_n = 1'b1;
    #1;
    checkOutput("fetch_state", state, 0);
    checkOutput("fetch_Load_PC", Load_PC, 1);
    checkOutput("fetch_Load_IR", Load_IR, 1);
    checkOutput("fetch_MemRead", MemRead, 1);
    checkOutput("fetch_ULAsrcB", ULAsrcB, 1);
    checkOutput("fetch_ULA_select", ULA_select, 1);

    // FETCH stall: no PC increment, state holds.
    mem_ready = 1'b0;
    #1;
    checkOutput("stall_Load_PC", Load_PC, 0);
    applyStimulus();
    checkOutput("stall_state", state, 0);
    mem_ready = 1'b1;

    // addi
    applyStimulus();
    checkOutput("addi_decode_state", state, 1);
    checkOutput("addi_decode_Load_A", Load_A, 1);
    checkOutput("addi_decode_ULAsrcB", ULAsrcB, 3);
    checkOutput("addi_decode_RegWrite", RegWrite, 0);
    applyStimulus();
    checkOutput("addi_ex_state", state, 4);
    checkOutput("addi_ex_ULAsrcB", ULAsrcB, 2);
    checkOutput("addi_ex_ULAsrcA", ULAsrcA, 1);
    checkOutput("addi_ex_RegWrite", RegWrite, 0);
    applyStimulus();
    checkOutput("addi_wb_state", state, 5);
    checkOutput("addi_wb_RegWrite", RegWrite, 1);
    checkOutput("addi_wb_WriteRegMux", WriteRegMux, 0);
    applyStimulus();
    checkOutput("addi_back_state", state, 0);

    // lw with three wait cycles in MEMRD
    opcode = 6'd35;
    applyStimulus();
    applyStimulus();
    checkOutput("lw_memadr_state", state, 6);
    mem_ready = 1'b0;
    applyStimulus();
    checkOutput("lw_memrd_state0", state, 7);
    checkOutput("lw_memrd_IorD", IorD, 1);
    checkOutput("lw_memrd_MemRead", MemRead, 1);
    checkOutput("lw_memrd_Load_MDR0", Load_MDR, 0);
    applyStimulus();
    checkOutput("lw_memrd_state1", state, 7);
    applyStimulus();
    checkOutput("lw_memrd_state2", state, 7);
    checkOutput("lw_memrd_Load_MDR2", Load_MDR, 0);
    mem_ready = 1'b1;
    #1;
    checkOutput("lw_memrd_Load_MDR_ready", Load_MDR, 1);
    applyStimulus();
    checkOutput("lw_memwb_state", state, 8);
    checkOutput("lw_memwb_WriteDataMux", WriteDataMux, 1);
    checkOutput("lw_memwb_RegWrite", RegWrite, 1);
    checkOutput("lw_memwb_Load_MDR", Load_MDR, 0);
    applyStimulus();
    checkOutput("lw_back_state", state, 0);

    // beq not taken, then taken
    opcode = 6'd4; zero = 1'b0;
    applyStimulus();
    applyStimulus();
    checkOutput("beq0_state", state, 10);
    checkOutput("beq0_Load_PC", Load_PC, 0);
    checkOutput("beq0_PCSource", PCSource, 1);
    checkOutput("beq0_ULA_select", ULA_select, 2);
    applyStimulus();
    applyStimulus();
    zero = 1'b1;
    applyStimulus();
    checkOutput("beq1_state", state, 10);
    checkOutput("beq1_Load_PC", Load_PC, 1);
    checkOutput("beq1_PCSource", PCSource, 1);
    applyStimulus();
    checkOutput("beq_back_state", state, 0);
    zero = 1'b0;

    // illegal opcode
    opcode = 6'd63;
    applyStimulus();
    applyStimulus();
    checkOutput("exc_state", state, 12);
    checkOutput("exc_exc", exc, 1);
    checkOutput("exc_PCSource", PCSource, 3);
    checkOutput("exc_Load_PC", Load_PC, 1);
    applyStimulus();
    checkOutput("exc_back_state", state, 0);
    checkOutput("exc_pulse_end", exc, 0);

    // R-type
    opcode = 6'd0;
    applyStimulus();
    applyStimulus();
    checkOutput("r_ex_state", state, 2);
    checkOutput("r_ex_ULA_select", ULA_select, 7);
    applyStimulus();
    checkOutput("r_wb_state", state, 3);
    checkOutput("r_wb_WriteRegMux", WriteRegMux, 1);
    applyStimulus();

    // jump
    opcode = 6'd2;
    applyStimulus();
    applyStimulus();
    checkOutput("j_state", state, 11);
    checkOutput("j_PCSource", PCSource, 2);
    checkOutput("j_Load_PC", Load_PC, 1);
    applyStimulus();
    checkOutput("j_back_state", state, 0);

    // sw stalled in MEMWR, then reset mid-access
    opcode = 6'd43;
    applyStimulus();
    applyStimulus();
    mem_ready = 1'b0;
    applyStimulus();
    checkOutput("sw_memwr_state", state, 9);
    checkOutput("sw_memwr_MemWrite", MemWrite, 1);
    checkOutput("sw_memwr_IorD", IorD, 1);
    applyStimulus();
    checkOutput("sw_stall_state", state, 9);
    reset_n = 1'b0;
    #1;
    checkOutput("sw_rst_MemWrite", MemWrite, 0);
    applyStimulus();
    checkOutput("sw_rst_state", state, 0);
    checkOutput("sw_rst_MemWrite_after", MemWrite, 0);
    reset_n = 1'b1;
    mem_ready = 1'b1;
    #1;
    checkOutput("sw_rst_fetch_MemRead", MemRead, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
